// File: rtl/sha256_host_link.sv
// Host-side driver for the sha256 core's narrow streaming port: takes a whole message,
// serialises it to the core, then collects and de-pads the returned digest.
module sha256_host_link #(
  parameter int unsigned MSG_LEN        = 640,
  parameter int unsigned WORD_W         = 10,
  parameter int unsigned DIGEST_W       = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MSG_LEN-1:0]  req_msg,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DIGEST_W-1:0] resp_digest,
  output logic                resp_error,
  output logic                busy,
  output logic                core_start,
  output logic                core_valid_in,
  output logic [WORD_W-1:0]   core_message_in,
  input  logic [WORD_W-1:0]   core_hash_out,
  input  logic                core_valid_out
);

  localparam int unsigned N_TX  = MSG_LEN / WORD_W;
  localparam int unsigned N_RX  = (DIGEST_W + WORD_W - 1) / WORD_W;
  localparam int unsigned RX_W  = N_RX * WORD_W;
  localparam int unsigned TX_CW = (N_TX > 1) ? $clog2(N_TX) : 1;
  localparam int unsigned RX_CW = (N_RX > 1) ? $clog2(N_RX) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [TX_CW-1:0] TX_LAST  = TX_CW'(N_TX - 1);
  localparam logic [RX_CW-1:0] RX_LAST  = RX_CW'(N_RX - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_RESP
  } state_t;

  state_t             state;
  logic [MSG_LEN-1:0] msg_sr;
  logic [RX_W-1:0]    rx_sr;
  logic [TX_CW-1:0]   tx_cnt;
  logic [RX_CW-1:0]   rx_cnt;
  logic [TMR_W-1:0]   timer;

  logic [RX_W-1:0]    rx_next;
  logic [TMR_W-1:0]   timer_inc;
  logic               timer_expired;

  always_comb begin
    rx_next       = {rx_sr[RX_W-WORD_W-1:0], core_hash_out};
    timer_inc     = (timer == '1) ? timer : timer + 1'b1;
    timer_expired = (timer == TMR_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      msg_sr          <= '0;
      rx_sr           <= '0;
      tx_cnt          <= '0;
      rx_cnt          <= '0;
      timer           <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_digest     <= '0;
      resp_error      <= 1'b0;
      busy            <= 1'b0;
      core_start      <= 1'b0;
      core_valid_in   <= 1'b0;
      core_message_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            msg_sr     <= req_msg;
            rx_sr      <= '0;
            rx_cnt     <= '0;
            timer      <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end

        // Message words are taken from the top of a left-shifting copy, so word n
        // is always the MSB-side slice n of the original message.
        S_START: begin
          core_start      <= 1'b0;
          core_valid_in   <= 1'b1;
          core_message_in <= msg_sr[MSG_LEN-1 -: WORD_W];
          msg_sr          <= msg_sr << WORD_W;
          tx_cnt          <= '0;
          state           <= S_SEND;
        end

        S_SEND: begin
          if (tx_cnt == TX_LAST) begin
            core_valid_in   <= 1'b0;
            core_message_in <= '0;
            timer           <= '0;
            state           <= S_WAIT;
          end else begin
            tx_cnt          <= tx_cnt + 1'b1;
            core_message_in <= msg_sr[MSG_LEN-1 -: WORD_W];
            msg_sr          <= msg_sr << WORD_W;
          end
        end

        S_WAIT: begin
          if (core_valid_out) begin
            rx_sr  <= rx_next;
            rx_cnt <= RX_CW'(1);
            timer  <= '0;
            state  <= S_RECV;
          end else if (timer_expired) begin
            resp_valid  <= 1'b1;
            resp_error  <= 1'b1;
            resp_digest <= '0;
            state       <= S_RESP;
          end else begin
            timer <= timer_inc;
          end
        end

        S_RECV: begin
          if (core_valid_out) begin
            rx_sr <= rx_next;
            timer <= '0;
            if (rx_cnt == RX_LAST) begin
              resp_valid  <= 1'b1;
              resp_error  <= 1'b0;
              resp_digest <= rx_next[RX_W-1 -: DIGEST_W];
              state       <= S_RESP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (timer_expired) begin
            resp_valid  <= 1'b1;
            resp_error  <= 1'b1;
            resp_digest <= '0;
            state       <= S_RESP;
          end else begin
            timer <= timer_inc;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_digest <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          state         <= S_IDLE;
          req_ready     <= 1'b1;
          busy          <= 1'b0;
          resp_valid    <= 1'b0;
          core_start    <= 1'b0;
          core_valid_in <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_host_link.sv
// Directed bench for sha256_host_link using a scripted stub in place of the core.
module tb_sha256_host_link;

  localparam int unsigned TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [639:0] req_msg = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [255:0] resp_digest;
  logic         resp_error;
  logic         busy;
  logic         core_start;
  logic         core_valid_in;
  logic [9:0]   core_message_in;
  logic [9:0]   core_hash_out = '0;
  logic         core_valid_out = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  sha256_host_link #(
    .MSG_LEN(640),
    .WORD_W(10),
    .DIGEST_W(256),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_msg(req_msg),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_digest(resp_digest),
    .resp_error(resp_error),
    .busy(busy),
    .core_start(core_start),
    .core_valid_in(core_valid_in),
    .core_message_in(core_message_in),
    .core_hash_out(core_hash_out),
    .core_valid_out(core_valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [639:0] ramp_msg();
    logic [639:0] m;
    m = '0;
    for (int n = 0; n < 64; n++) m[639-10*n -: 10] = 10'(n);
    return m;
  endfunction

  // Presents a request and returns #1 after the accepting edge (DUT in START).
  task automatic do_request(input logic [639:0] msg);
    int  n;
    logic rdy;
    req_msg   = msg;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1 req_valid = 1'b0;
    tests_run++;
    if (!rdy) begin
      tests_failed++;
      $display("FAIL req_accept: req_ready never seen, got %b want 1", rdy);
    end
  endtask

  task automatic feed_hash(input int first, input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      core_valid_out = 1'b1;
      core_hash_out  = 10'(first + i);
      @(posedge clk);
      #1 core_valid_out = 1'b0;
      if (i != count - 1)
        repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({req_ready, busy, resp_valid, resp_error, core_start, core_valid_in} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 100000",
               {req_ready, busy, resp_valid, resp_error, core_start, core_valid_in});
    end
    tests_run++;
    if (resp_digest !== '0 || core_message_in !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: digest %h msg %h want 0", resp_digest, core_message_in);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_send(input logic [639:0] msg, input bit ramp);
    int bad;
    do_request(msg);
    @(negedge clk);
    tests_run++;
    if (core_start !== 1'b1 || core_valid_in !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_start: start %b vin %b busy %b want 1 0 1", core_start, core_valid_in, busy);
    end
    bad = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (core_start !== 1'b0 || core_valid_in !== 1'b1 ||
          core_message_in !== (ramp ? 10'(n) : 10'h2AA)) begin
        if (bad == 0)
          $display("FAIL send_word %0d: start %b vin %b msg %h want 0 1 %h", n, core_start,
                   core_valid_in, core_message_in, ramp ? 10'(n) : 10'h2AA);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    @(negedge clk);
    tests_run++;
    if (core_valid_in !== 1'b0 || core_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL send_end: vin %b start %b want 0 0", core_valid_in, core_start);
    end
    @(posedge clk);
    #1 feed_hash(0, 26, 0);
    handshake();
  endtask

  task automatic test_digest(input int gap);
    do_request(ramp_msg());
    repeat (65) @(posedge clk);
    #1 feed_hash(1, 26, gap);
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL digest_gap%0d_valid: valid %b err %b want 1 0", gap, resp_valid, resp_error);
    end
    tests_run++;
    if (resp_digest[255:246] !== 10'd1 || resp_digest[245:236] !== 10'd2 ||
        resp_digest[15:6] !== 10'd25 || resp_digest[5:0] !== 6'd1) begin
      tests_failed++;
      $display("FAIL digest_gap%0d_fields: %h %h %h %h want 001 002 019 01", gap,
               resp_digest[255:246], resp_digest[245:236], resp_digest[15:6], resp_digest[5:0]);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int c;
    do_request({64{10'h155}});
    repeat (65) @(posedge clk);
    #1 c = 0;
    while (resp_valid !== 1'b1 && c < TMO + 20) begin
      @(posedge clk);
      #1 c++;
    end
    tests_run++;
    if (c != TMO || resp_error !== 1'b1 || resp_digest !== '0) begin
      tests_failed++;
      $display("FAIL timeout_wait: cycles %0d err %b digest %h want %0d 1 0", c, resp_error,
               resp_digest, TMO);
    end
    handshake();
    do_request({64{10'h155}});
    repeat (65) @(posedge clk);
    #1 feed_hash(5, 10, 0);
    c = 0;
    while (resp_valid !== 1'b1 && c < TMO + 20) begin
      @(posedge clk);
      #1 c++;
    end
    tests_run++;
    if (c != TMO || resp_error !== 1'b1 || resp_digest !== '0) begin
      tests_failed++;
      $display("FAIL timeout_stall: cycles %0d err %b digest %h want %0d 1 0", c, resp_error,
               resp_digest, TMO);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [255:0] snap;
    int bad;
    do_request({64{10'h2AA}});
    repeat (65) @(posedge clk);
    #1 feed_hash(1, 26, 0);
    @(negedge clk);
    snap = resp_digest;
    req_msg   = ramp_msg();
    req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      core_valid_out = i[0];
      core_hash_out  = 10'h3FF;
      @(negedge clk);
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_digest !== snap ||
          resp_digest[255:246] !== 10'd1) begin
        if (bad == 0)
          $display("FAIL hold_stable cyc %0d: valid %b rdy %b digest %h want 1 0 %h", i,
                   resp_valid, req_ready, resp_digest, snap);
        bad++;
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    core_valid_out = 1'b0;
    handshake();
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_handshake: rdy %b valid %b busy %b want 1 0 0", req_ready, resp_valid, busy);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (core_start !== 1'b1 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_start: start %b rdy %b want 1 0", core_start, req_ready);
    end
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, busy, resp_valid, core_start, core_valid_in} !== 5'b10000 ||
        core_message_in !== '0) begin
      tests_failed++;
      $display("FAIL reset_midsend: ctrl %b msg %h want 10000 000",
               {req_ready, busy, resp_valid, core_start, core_valid_in}, core_message_in);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1 || core_valid_in !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset: rdy %b vin %b busy %b want 1 0 0", req_ready, core_valid_in, busy);
    end
  endtask

  initial begin
    test_reset();
    test_send({64{10'h2AA}}, 1'b0);
    test_send(ramp_msg(), 1'b1);
    test_digest(0);
    test_digest(3);
    test_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
